// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and helpers for the register file with scoreboard
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;

    // Architectural zero register index
    localparam int unsigned REG_ZERO = '0;

    // Widest busy vector the popcount helper accepts; narrower vectors are zero-extended
    localparam int MAX_NREGS = 1024;

    function automatic int popcount(input logic [MAX_NREGS-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < MAX_NREGS; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - busy-bit scoreboard: reservation on issue, release on writeback, flush
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int   NREGS = NREGS_DEF,
    localparam int  AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_rd,
    input  logic             flush,
    output logic [NREGS-1:0] busy,
    output logic             iss_ready,
    output logic [AW:0]      busy_cnt
);

    logic [NREGS-1:0] busy_next;
    logic             fire;

    // A destination may be reserved when it is free, is r0, or is being released this very cycle
    always_comb begin
        iss_ready = (iss_rd == AW'(REG_ZERO)) | ~busy[iss_rd] | (we & (wa == iss_rd));
        fire      = iss_valid & iss_ready & ~flush;
    end

    // Next busy vector: release first, then reserve so a colliding issue keeps the bit set; flush wins over both
    always_comb begin
        busy_next = busy;
        if (we && wa != AW'(REG_ZERO)) begin
            busy_next[wa] = 1'b0;
        end
        if (fire && iss_rd != AW'(REG_ZERO)) begin
            busy_next[iss_rd] = 1'b1;
        end
        if (flush) begin
            busy_next = '0;
        end
        busy_next[REG_ZERO] = 1'b0;
    end

    // Busy bits and their registered count advance together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= (AW+1)'(popcount(MAX_NREGS'(busy_next)));
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - multi-port register file with busy scoreboard; optional RF_WRITE_BYPASS_EN
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int   XLEN  = XLEN_DEF,
    parameter int   NREGS = NREGS_DEF,
    parameter int   NRD   = NRD_DEF,
    localparam int  AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rd_busy,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic                iss_ready,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;

    rf_scoreboard #(
        .NREGS(NREGS)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .wa       (wa),
        .iss_valid(iss_valid),
        .iss_rd   (iss_rd),
        .flush    (flush),
        .busy     (busy),
        .iss_ready(iss_ready),
        .busy_cnt (busy_cnt)
    );

    // Storage: writeback updates any register except r0, which stays zero from reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && wa != AW'(REG_ZERO)) begin
            regs[wa] <= wd;
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            bsy;

        assign addr = ra[g*AW +: AW];

        // Combinational read: r0 is forced to zero and never busy
        always_comb begin
            data = regs[addr];
            bsy  = busy[addr];
            if (addr == AW'(REG_ZERO)) begin
                data = '0;
                bsy  = 1'b0;
            end
`ifdef RF_WRITE_BYPASS_EN
            else if (we && wa == addr) begin
                data = wd;
                bsy  = 1'b0;
            end
`endif
        end

        assign rd[g*XLEN +: XLEN] = data;
        assign rd_busy[g]         = bsy;
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - self-checking bench for reg_file_sb against a behavioural model
module tb_reg_file_sb;

    localparam int XLEN  = 64;
    localparam int NREGS = 16;
    localparam int NRD   = 3;
    localparam int AW    = 4;

    logic                clk;
    logic                clk_en;
    logic                rst_n;
    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      rd_busy;
    logic                we;
    logic [AW-1:0]       wa;
    logic [XLEN-1:0]     wd;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic                iss_ready;
    logic                flush;
    logic [AW:0]         busy_cnt;

    int checks   = 0;
    int failures = 0;

    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];

    reg_file_sb #(
        .XLEN (XLEN),
        .NREGS(NREGS),
        .NRD  (NRD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra       (ra),
        .rd       (rd),
        .rd_busy  (rd_busy),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .iss_valid(iss_valid),
        .iss_rd   (iss_rd),
        .iss_ready(iss_ready),
        .flush    (flush),
        .busy_cnt (busy_cnt)
    );

    initial clk = 0;
    always #5 if (clk_en) clk = ~clk;

    // ---------------- behavioural model ----------------
    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef RF_WRITE_BYPASS_EN
        if (we && wa == a) return wd;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
`ifdef RF_WRITE_BYPASS_EN
        if (we && wa == a) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    function automatic logic exp_ready();
        return (iss_rd == 0) || !m_busy[iss_rd] || (we && wa == iss_rd);
    endfunction

    function automatic int exp_cnt();
        int n = 0;
        for (int i = 0; i < NREGS; i++) n += m_busy[i] ? 1 : 0;
        return n;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 0;
        end
    endfunction

    // Advance model and DUT by one clock edge with the inputs currently applied
    task automatic clock_edge();
        bit fire;
        fire = iss_valid && exp_ready() && !flush;
        @(posedge clk);
        if (we && wa != 0) m_regs[wa] = wd;
        if (flush) begin
            for (int i = 0; i < NREGS; i++) m_busy[i] = 0;
        end else begin
            if (we && wa != 0) m_busy[wa] = 0;
            if (fire && iss_rd != 0) m_busy[iss_rd] = 1;
        end
        #1;
    endtask

    task automatic idle();
        we = 0; wa = '0; wd = '0; iss_valid = 0; iss_rd = '0; flush = 0;
    endtask

    task automatic set_ra(input int p, input logic [AW-1:0] a);
        ra[p*AW +: AW] = a;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clk_en = 0;
        rst_n  = 0;
        idle();
        iss_rd = 4'd5;
        set_ra(0, 4'd3); set_ra(1, 4'd9); set_ra(2, 4'd15);
        m_reset();
        #1;
        for (int p = 0; p < NRD; p++) begin
            checks++;
            if (rd[p*XLEN +: XLEN] !== '0 || rd_busy[p] !== 1'b0) begin
                failures++;
                $display("FAIL reset_rd_p%0d: got data=%h busy=%b expected 0/0", p, rd[p*XLEN +: XLEN], rd_busy[p]);
            end
        end
        checks++;
        if (busy_cnt !== '0 || iss_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_status: got cnt=%0d ready=%b expected 0/1", busy_cnt, iss_ready);
        end
        rst_n  = 1;
        #2;
        clk_en = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        idle();
        we = 1; wa = 4'd5; wd = 64'hDEADBEEF;
        clock_edge();
        idle();
        set_ra(0, 4'd5);
        #1;
        checks++;
        if (rd[0 +: XLEN] !== 64'hDEADBEEF) begin
            failures++;
            $display("FAIL write_read: got %h expected %h", rd[0 +: XLEN], 64'hDEADBEEF);
        end
        we = 1; wa = 4'd0; wd = 64'd1;
        clock_edge();
        idle();
        set_ra(0, 4'd0);
        #1;
        checks++;
        if (rd[0 +: XLEN] !== '0 || rd_busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL r0_write: got data=%h busy=%b expected 0/0", rd[0 +: XLEN], rd_busy[0]);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        iss_valid = 1; iss_rd = 4'd7;
        #1;
        checks++;
        if (iss_ready !== 1'b1) begin
            failures++;
            $display("FAIL sb_ready_free: got %b expected 1", iss_ready);
        end
        clock_edge();
        idle();
        iss_rd = 4'd7;
        set_ra(0, 4'd7);
        #1;
        checks++;
        if (rd_busy[0] !== 1'b1 || busy_cnt !== 5'd1 || iss_ready !== 1'b0) begin
            failures++;
            $display("FAIL sb_reserved: got busy=%b cnt=%0d ready=%b expected 1/1/0", rd_busy[0], busy_cnt, iss_ready);
        end
        we = 1; wa = 4'd7; wd = {$urandom, $urandom};
        #1;
        checks++;
        if (iss_ready !== 1'b1) begin
            failures++;
            $display("FAIL sb_ready_release: got %b expected 1", iss_ready);
        end
        clock_edge();
        idle();
        set_ra(0, 4'd7);
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0 || busy_cnt !== 5'd0) begin
            failures++;
            $display("FAIL sb_released: got busy=%b cnt=%0d expected 0/0", rd_busy[0], busy_cnt);
        end
    endtask

    task automatic test_collision();
        int cnt_before;
        idle();
        iss_valid = 1; iss_rd = 4'd3;
        clock_edge();
        idle();
        #1;
        cnt_before = exp_cnt();
        we = 1; wa = 4'd3; wd = 64'd9; iss_valid = 1; iss_rd = 4'd3;
        #1;
        checks++;
        if (iss_ready !== 1'b1) begin
            failures++;
            $display("FAIL collide_ready: got %b expected 1", iss_ready);
        end
        clock_edge();
        idle();
        set_ra(1, 4'd3);
        #1;
        checks++;
        if (rd[XLEN +: XLEN] !== 64'd9 || rd_busy[1] !== 1'b1 || int'(busy_cnt) != cnt_before) begin
            failures++;
            $display("FAIL collide_state: got data=%0d busy=%b cnt=%0d expected 9/1/%0d",
                     rd[XLEN +: XLEN], rd_busy[1], busy_cnt, cnt_before);
        end
    endtask

    task automatic test_flush();
        idle();
        flush = 1;
        clock_edge();
        idle();
        iss_valid = 1;
        iss_rd = 4'd1; clock_edge();
        iss_rd = 4'd2; clock_edge();
        iss_rd = 4'd4; clock_edge();
        idle();
        #1;
        checks++;
        if (busy_cnt !== 5'd3) begin
            failures++;
            $display("FAIL flush_setup: got cnt=%0d expected 3", busy_cnt);
        end
        flush = 1; iss_valid = 1; iss_rd = 4'd6;
        clock_edge();
        idle();
        set_ra(0, 4'd6); set_ra(1, 4'd1); set_ra(2, 4'd4);
        #1;
        checks++;
        if (busy_cnt !== 5'd0 || rd_busy !== 3'b000) begin
            failures++;
            $display("FAIL flush_clear: got cnt=%0d busy=%b expected 0/000", busy_cnt, rd_busy);
        end
    endtask

    task automatic test_bypass();
        idle();
        we = 1; wa = 4'd10; wd = 64'd123;
        clock_edge();
        idle();
        iss_valid = 1; iss_rd = 4'd10;
        clock_edge();
        idle();
        we = 1; wa = 4'd10; wd = 64'd55;
        set_ra(1, 4'd10);
        #1;
        checks++;
`ifdef RF_WRITE_BYPASS_EN
        if (rd[XLEN +: XLEN] !== 64'd55 || rd_busy[1] !== 1'b0) begin
            failures++;
            $display("FAIL bypass_same_cycle: got data=%0d busy=%b expected 55/0", rd[XLEN +: XLEN], rd_busy[1]);
        end
`else
        if (rd[XLEN +: XLEN] !== 64'd123 || rd_busy[1] !== 1'b1) begin
            failures++;
            $display("FAIL bypass_same_cycle: got data=%0d busy=%b expected 123/1", rd[XLEN +: XLEN], rd_busy[1]);
        end
`endif
        clock_edge();
        idle();
        #1;
        checks++;
        if (rd[XLEN +: XLEN] !== 64'd55 || rd_busy[1] !== 1'b0) begin
            failures++;
            $display("FAIL bypass_next_cycle: got data=%0d busy=%b expected 55/0", rd[XLEN +: XLEN], rd_busy[1]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            we        = ($urandom_range(0, 2) != 0);
            wa        = AW'($urandom_range(0, 7));
            wd        = {$urandom, $urandom};
            iss_valid = ($urandom_range(0, 3) != 0);
            iss_rd    = AW'($urandom_range(0, 15));
            flush     = ($urandom_range(0, 19) == 0);
            for (int p = 0; p < NRD; p++) begin
                set_ra(p, (p == 0) ? wa : AW'($urandom_range(0, 15)));
            end
            #1;
            for (int p = 0; p < NRD; p++) begin
                checks++;
                if (rd[p*XLEN +: XLEN] !== exp_rd(ra[p*AW +: AW]) || rd_busy[p] !== exp_busy(ra[p*AW +: AW])) begin
                    failures++;
                    $display("FAIL rand_read c%0d p%0d: got data=%h busy=%b expected %h/%b", c, p,
                             rd[p*XLEN +: XLEN], rd_busy[p], exp_rd(ra[p*AW +: AW]), exp_busy(ra[p*AW +: AW]));
                end
            end
            checks++;
            if (iss_ready !== exp_ready() || int'(busy_cnt) != exp_cnt()) begin
                failures++;
                $display("FAIL rand_status c%0d: got ready=%b cnt=%0d expected %b/%0d", c,
                         iss_ready, busy_cnt, exp_ready(), exp_cnt());
            end
            clock_edge();
        end
        idle();
    endtask

    task automatic test_async_reset();
        idle();
        we = 1; wa = 4'd2; wd = 64'hABCD;
        clock_edge();
        idle();
        iss_valid = 1; iss_rd = 4'd9;
        clock_edge();
        we = 1; wa = 4'd12; wd = 64'h77;
        iss_valid = 1; iss_rd = 4'd13;
        #2;
        rst_n = 0;
        m_reset();
        #1;
        checks++;
        if (busy_cnt !== '0) begin
            failures++;
            $display("FAIL async_reset_cnt: got %0d expected 0", busy_cnt);
        end
        @(posedge clk); #1;
        idle();
        iss_rd = 4'd9;
        for (int a = 0; a < NREGS; a++) begin
            set_ra(0, AW'(a));
            #1;
            checks++;
            if (rd[0 +: XLEN] !== '0 || rd_busy[0] !== 1'b0) begin
                failures++;
                $display("FAIL async_reset_r%0d: got data=%h busy=%b expected 0/0", a, rd[0 +: XLEN], rd_busy[0]);
            end
        end
        checks++;
        if (iss_ready !== 1'b1 || busy_cnt !== '0) begin
            failures++;
            $display("FAIL async_reset_status: got ready=%b cnt=%0d expected 1/0", iss_ready, busy_cnt);
        end
        @(negedge clk);
        rst_n = 1;
        clock_edge();
        set_ra(0, 4'd12);
        #1;
        checks++;
        if (rd[0 +: XLEN] !== '0) begin
            failures++;
            $display("FAIL async_reset_lost_write: got %h expected 0", rd[0 +: XLEN]);
        end
    endtask

    initial begin
        ra = '0;
        test_reset();
        test_write_read();
        test_scoreboard();
        test_collision();
        test_flush();
        test_bypass();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
